// File: rtl/arith_unit_arbiter.sv
// Round-robin front end that shares one fixed-latency arithmetic unit between two requesters.
// Accepts one operation at a time, drives the unit, then holds the tagged response until it is consumed.
module arith_unit_arbiter #(
    parameter int BITS = 32,
    parameter int LAT  = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [BITS-1:0] i_req0_arg_A,
    input  logic [BITS-1:0] i_req0_arg_B,
    input  logic [1:0]      i_req0_op,
    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [BITS-1:0] i_req1_arg_A,
    input  logic [BITS-1:0] i_req1_arg_B,
    input  logic [1:0]      i_req1_op,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic            o_rsp_id,
    output logic [BITS-1:0] o_rsp_result,
    output logic [3:0]      o_rsp_status,
    output logic [BITS-1:0] o_alu_arg_A,
    output logic [BITS-1:0] o_alu_arg_B,
    output logic [1:0]      o_alu_op,
    input  logic [BITS-1:0] i_alu_result,
    input  logic [3:0]      i_alu_status,
    output logic            o_busy
);

    localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            last_grant_q;
    logic            rsp_id_q;
    logic [BITS-1:0] rsp_result_q;
    logic [3:0]      rsp_status_q;
    logic [BITS-1:0] alu_a_q;
    logic [BITS-1:0] alu_b_q;
    logic [1:0]      alu_op_q;

    logic            gnt0;
    logic            gnt1;
    logic            accept;
    logic [BITS-1:0] alu_a_d;
    logic [BITS-1:0] alu_b_d;
    logic [1:0]      alu_op_d;

    // Under contention the requester that did not win last time is served.
    always_comb begin
        gnt0     = i_req0_valid && (!i_req1_valid || last_grant_q);
        gnt1     = i_req1_valid && (!i_req0_valid || !last_grant_q);
        accept   = (state_q == IDLE) && (gnt0 || gnt1);
        alu_a_d  = gnt1 ? i_req1_arg_A : i_req0_arg_A;
        alu_op_d = gnt1 ? i_req1_op    : i_req0_op;
        alu_b_d  = gnt1 ? i_req1_arg_B : i_req0_arg_B;
        if (alu_op_d == 2'd2) begin
            alu_b_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q      <= alu_a_d;
                        alu_b_q      <= alu_b_d;
                        alu_op_q     <= alu_op_d;
                        last_grant_q <= gnt1;
                        rsp_id_q     <= gnt1;
                        cnt_q        <= CW'(LAT);
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // Count 0 is the cycle the unit output reflects the held operands.
                    if (cnt_q == '0) begin
                        rsp_result_q <= i_alu_result;
                        rsp_status_q <= i_alu_status;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_req0_ready = (state_q == IDLE) && gnt0;
    assign o_req1_ready = (state_q == IDLE) && gnt1;
    assign o_rsp_valid  = (state_q == RESP);
    assign o_busy       = (state_q != IDLE);
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_status = rsp_status_q;
    assign o_alu_arg_A  = alu_a_q;
    assign o_alu_arg_B  = alu_b_q;
    assign o_alu_op     = alu_op_q;

endmodule

// File: tb/tb_arith_unit_arbiter.sv
// Directed bench for arith_unit_arbiter with a one-cycle-latency arithmetic unit model.
// Inputs change on the falling edge; outputs are sampled just after an edge.
module tb_arith_unit_arbiter;

    localparam int BITS = 32;
    localparam int LAT  = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            v0 = 1'b0, v1 = 1'b0, rsp_ready = 1'b0;
    logic [BITS-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]      op0 = '0, op1 = '0;
    logic            ready0, ready1, rsp_valid, rsp_id, busy;
    logic [BITS-1:0] rsp_result, alu_a, alu_b;
    logic [3:0]      rsp_status;
    logic [1:0]      alu_op;
    logic [BITS-1:0] alu_res;
    logic [3:0]      alu_stat;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    arith_unit_arbiter #(.BITS(BITS), .LAT(LAT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req0_valid(v0), .o_req0_ready(ready0),
        .i_req0_arg_A(a0), .i_req0_arg_B(b0), .i_req0_op(op0),
        .i_req1_valid(v1), .o_req1_ready(ready1),
        .i_req1_arg_A(a1), .i_req1_arg_B(b1), .i_req1_op(op1),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id), .o_rsp_result(rsp_result), .o_rsp_status(rsp_status),
        .o_alu_arg_A(alu_a), .o_alu_arg_B(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_res), .i_alu_status(alu_stat),
        .o_busy(busy)
    );

    // Unit model: op0 add, op1 sub, op2 not A, op3 xor; status = {zero, sign, op}.
    function automatic logic [BITS-1:0] unit_res(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                                 input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return ~a;
            default: return a ^ b;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res  <= '0;
            alu_stat <= 4'b1000;
        end else begin
            alu_res  <= unit_res(alu_a, alu_b, alu_op);
            alu_stat <= {unit_res(alu_a, alu_b, alu_op) == '0, unit_res(alu_a, alu_b, alu_op)[BITS-1], alu_op};
        end
    end

    task automatic test_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ready0, ready1, busy, rsp_valid} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {ready0, ready1, busy, rsp_valid});
        else n_pass++;
        n_checks++;
        if ({rsp_id, rsp_result, rsp_status} !== 37'h0)
            $display("FAIL reset_rsp: got %h expected 0", {rsp_id, rsp_result, rsp_status});
        else n_pass++;
        n_checks++;
        if ({alu_a, alu_b, alu_op} !== 66'h0)
            $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_op});
        else n_pass++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        rsp_ready = 1'b0; v0 = 1'b1; a0 = 32'd5; b0 = 32'd7; op0 = 2'd0;
        #1;
        n_checks++;
        if (ready0 !== 1'b1) $display("FAIL basic_ready: got %b expected 1", ready0);
        else n_pass++;
        @(posedge clk); #1;
        v0 = 1'b0;
        n_checks++;
        if ({alu_a, alu_b, alu_op} !== {32'd5, 32'd7, 2'd0})
            $display("FAIL basic_alu_ops: got %h expected %h", {alu_a, alu_b, alu_op}, {32'd5, 32'd7, 2'd0});
        else n_pass++;
        n_checks++;
        if ({busy, ready0} !== 2'b10) $display("FAIL basic_busy: got %b expected 10", {busy, ready0});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL basic_early_rsp: got %b expected 0", rsp_valid);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_status} !== {1'b1, 1'b0, 32'd12, 4'h0})
            $display("FAIL basic_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_result, rsp_status},
                     {1'b1, 1'b0, 32'd12, 4'h0});
        else n_pass++;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, rsp_valid} !== 2'b00) $display("FAIL basic_release: got %b expected 00", {busy, rsp_valid});
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int grant_ids[$];
        int grant_cyc[$];
        logic            exp_id_q[$];
        logic [BITS-1:0] exp_q[$];
        logic            eid;
        logic [BITS-1:0] eres;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        a0 = 32'd100; b0 = 32'd3;  op0 = 2'd1;
        a1 = 32'h10;  b1 = 32'h20; op1 = 2'd3;
        rsp_ready = 1'b1; v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (exp_id_q.size() == 0) begin
                    $display("FAIL rr_rsp_unexpected: got id %b expected no response", rsp_id);
                end else begin
                    eid = exp_id_q.pop_front();
                    eres = exp_q.pop_front();
                    if ({rsp_id, rsp_result} !== {eid, eres})
                        $display("FAIL rr_rsp: got %h expected %h", {rsp_id, rsp_result}, {eid, eres});
                    else n_pass++;
                end
            end
            if (v0 && ready0) begin
                grant_ids.push_back(0); grant_cyc.push_back(i);
                exp_id_q.push_back(1'b0); exp_q.push_back(32'd97);
            end
            if (v1 && ready1) begin
                grant_ids.push_back(1); grant_cyc.push_back(i);
                exp_id_q.push_back(1'b1); exp_q.push_back(32'h30);
            end
            if (grant_ids.size() >= 4 && (v0 || v1)) begin
                @(posedge clk); #1;
                v0 = 1'b0; v1 = 1'b0;
            end
            if (grant_ids.size() >= 4 && exp_id_q.size() == 0) break;
        end
        n_checks++;
        if (grant_ids.size() != 4) $display("FAIL rr_grant_count: got %0d expected 4", grant_ids.size());
        else n_pass++;
        for (int k = 0; k < grant_ids.size() && k < 4; k++) begin
            n_checks++;
            if (grant_ids[k] != (k % 2)) $display("FAIL rr_grant_%0d: got %0d expected %0d", k, grant_ids[k], k % 2);
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (grant_cyc[k] - grant_cyc[k-1] != LAT + 3)
                    $display("FAIL rr_spacing_%0d: got %0d expected %0d", k, grant_cyc[k] - grant_cyc[k-1], LAT + 3);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_id_q.size() != 0) $display("FAIL rr_drain: got %0d pending expected 0", exp_id_q.size());
        else n_pass++;
    endtask

    task automatic test_unary();
        @(negedge clk);
        rsp_ready = 1'b0; v0 = 1'b0;
        v1 = 1'b1; a1 = 32'h1234; b1 = 32'hFFFF_FFFF; op1 = 2'd2;
        #1;
        n_checks++;
        if ({ready0, ready1} !== 2'b01) $display("FAIL unary_ready: got %b expected 01", {ready0, ready1});
        else n_pass++;
        @(posedge clk); #1;
        v1 = 1'b0;
        n_checks++;
        if ({alu_a, alu_b, alu_op} !== {32'h1234, 32'h0, 2'd2})
            $display("FAIL unary_alu_ops: got %h expected %h", {alu_a, alu_b, alu_op}, {32'h1234, 32'h0, 2'd2});
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_valid === 1'b1) break;
        end
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_status} !== {1'b1, 1'b1, 32'hFFFF_EDCB, 4'b0110})
            $display("FAIL unary_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_result, rsp_status},
                     {1'b1, 1'b1, 32'hFFFF_EDCB, 4'b0110});
        else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 1'b0; v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; op0 = 2'd0;
        @(posedge clk); #1;
        v0 = 1'b0;
        v1 = 1'b1; a1 = 32'hF0; b1 = 32'h0F; op1 = 2'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_valid === 1'b1) break;
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(negedge clk); #1;
            end
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_status, ready0, ready1} !== {1'b1, 1'b0, 32'd3, 4'h0, 2'b00})
                $display("FAIL bp_hold_%0d: got %h expected %h", c,
                         {rsp_valid, rsp_id, rsp_result, rsp_status, ready0, ready1},
                         {1'b1, 1'b0, 32'd3, 4'h0, 2'b00});
            else n_pass++;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (ready1 !== 1'b0) $display("FAIL bp_same_cycle_accept: got %b expected 0", ready1);
        else n_pass++;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++;
        if ({busy, rsp_valid, ready1} !== 3'b001)
            $display("FAIL bp_idle_next: got %b expected 001", {busy, rsp_valid, ready1});
        else n_pass++;
        @(posedge clk); #1;
        v1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_valid === 1'b1) break;
        end
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_status} !== {1'b1, 1'b1, 32'hFF, 4'b0011})
            $display("FAIL bp_second_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_result, rsp_status},
                     {1'b1, 1'b1, 32'hFF, 4'b0011});
        else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_exec();
        logic saw_rsp;
        @(negedge clk);
        v0 = 1'b1; v1 = 1'b0; a0 = 32'd9; b0 = 32'd9; op0 = 2'd0;
        @(posedge clk); #1;
        v0 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, rsp_valid, alu_a, alu_b, alu_op} !== 68'h0)
            $display("FAIL rst_exec_async: got %h expected 0", {busy, rsp_valid, alu_a, alu_b, alu_op});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        n_checks++;
        if (saw_rsp !== 1'b0) $display("FAIL rst_exec_no_rsp: got %b expected 0", saw_rsp);
        else n_pass++;
        v0 = 1'b1; v1 = 1'b1;
        #1;
        n_checks++;
        if ({ready0, ready1} !== 2'b10) $display("FAIL rst_exec_grant: got %b expected 10", {ready0, ready1});
        else n_pass++;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_unary();
        test_backpressure();
        test_reset_exec();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
